uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Parametrised UART receive engine for the UART_RX path. It contains its own oversampling edge/bit counters, majority-vote sampler, deserializer, parity checker and stop checker. It adds runtime-selectable prescale, odd/even parity, one or two stop bits, and break-frame detection. It takes the already-synchronised serial line and produces a parallel word with a one-cycle valid pulse and per-frame error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- S_DATA  in  1  serial line, already synchronised to CLK upstream; idles at 1.
- parity_enable  in  1  1 = a parity bit follows the data bits.
- parity_type  in  1  0 = even parity, 1 = odd parity.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- prescale  in  PRESCALE_W  oversampling ratio P; legal values 8, 16, 32.
- P_DATA  out  DATA_WIDTH  last good received word.
- data_valid  out  1  one-cycle pulse; P_DATA is updated and error-free.
- par_err  out  1  one-cycle pulse; the frame had a parity mismatch.
- stp_err  out  1  one-cycle pulse; a stop bit was sampled as 0.
- break_det  out  1  one-cycle pulse; a break frame was received.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Configuration inputs (parity_enable, parity_type, stop_bits, prescale) are latched on the IDLE->START transition. Changes in mid-frame are ignored.
- A latched prescale value other than 16 or 32 behaves as 8.
- Each bit lasts P cycles. edge_cnt runs 0..P-1 and then wraps while bit_cnt increments.
- Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples.
- States: IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT.
- IDLE: when S_DATA=0 is seen, go to START with edge_cnt=1. The detection cycle counts as edge 0 of the start bit.
- START: in the cycle after the last sample, a majority of 1 (glitch) sends the FSM to IDLE with no output pulse. Otherwise the FSM stays in START until edge_cnt=P-1, then goes to DATA.
- DATA: DATA_WIDTH bits, LSB first, shifted in from the MSB end. After the last bit's edge P-1, go to PARITY if parity_enable, else STOP.
- PARITY: the expected value is ^data for even parity and ~^data for odd parity. A mismatch sets the internal parity-error flag.
- STOP: one or two stop bits. Any stop bit whose majority is 0 sets the internal stop-error flag. In the cycle after the final sample of the last stop bit, go to DONE. The remaining half stop bit is not waited out.
- Output pulses are registered. They are asserted during the single DONE cycle and are 0 otherwise.
- Break frame: all data bits, the parity bit (if enabled) and the first stop bit are sampled 0. Result: break_det=1, data_valid=0, par_err=0, stp_err=0. DONE then goes to BRK_WAIT.
- Error frame (not a break) with either error flag set: the corresponding par_err/stp_err pulse is driven, data_valid=0, and P_DATA is unchanged.
- Good frame: data_valid=1 and P_DATA is loaded on the edge entering DONE.
- DONE: if S_DATA=0, go to START with edge_cnt=1, giving back-to-back frames with no lost cycle. Otherwise go to IDLE.
- BRK_WAIT: stay until S_DATA=1, then go to IDLE.
- par_err is never asserted when parity_enable=0.

## Timing
- Cycle 0 is the IDLE cycle where S_DATA=0 is first seen. Bit k (start bit is k=0) occupies cycles P*k .. P*k+P-1.
- The last bit index is n = DATA_WIDTH + parity_enable + (stop_bits ? 2 : 1).
- The final sample is at cycle P*n + P/2 + 1. DONE, and the output pulses, occur at cycle P*n + P/2 + 2.
  - Example: 8N1 with P=8 gives n=9, so the pulse is at cycle 78.
- A start glitch returns the FSM to IDLE at cycle P/2+2.
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0, break_det=0, busy=0; state IDLE; counters 0.
- Reset asserted mid-frame aborts the frame immediately, with no pulse.
- After reset is released with S_DATA=0, a frame starts normally. The glitch and break logic handle a line that is stuck low.

## Test plan
- 8N1, P=8, byte 0xA5 -> data_valid high only at cycle 78, P_DATA=0xA5, all error flags 0, busy high from cycle 1 to cycle 78.
- 8E1, P=16, byte 0x3C with a correct parity bit (0) -> data_valid=1, P_DATA=0x3C. Same frame with parity bit 1 -> par_err=1, data_valid=0, P_DATA still 0x3C.
- 7O2, P=32 (DATA_WIDTH=7), second stop bit driven 0 -> stp_err pulse at cycle 32*10+18=338, data_valid=0.
- 8N1, P=8, S_DATA low for 3 cycles only -> no output pulse, FSM back in IDLE at cycle 6, busy=0 from cycle 6.
- Line held low for 20 bit times, then released -> break_det pulse at cycle 78, FSM in BRK_WAIT until S_DATA=1, no data_valid. A following 0x55 frame is received correctly.
- Two back-to-back 8N1 frames (0x01 then 0xFE) with the second start bit beginning 4 cycles after the first pulse -> two data_valid pulses. RST asserted mid-second-frame -> all outputs 0 at once, no second pulse.

Source files
------------

// File: rtl/uart_rx_engine_if.sv
// UART receive engine bus: serial line and frame configuration in,
// received word and per-frame status pulses out.
interface uart_rx_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  S_DATA;
    logic                  parity_enable;
    logic                  parity_type;
    logic                  stop_bits;
    logic [PRESCALE_W-1:0] prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  break_det;
    logic                  busy;

    modport master (
        output S_DATA, parity_enable, parity_type, stop_bits, prescale,
        input  P_DATA, data_valid, par_err, stp_err, break_det, busy
    );

    modport slave (
        input  S_DATA, parity_enable, parity_type, stop_bits, prescale,
        output P_DATA, data_valid, par_err, stp_err, break_det, busy
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled majority-vote receiver with parity,
// one/two stop bits and break detection; status outputs are 1-cycle pulses.
module uart_rx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input logic             CLK,
    input logic             RST,
    uart_rx_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [5:0]            p_q, p_d;
    logic                  pe_q, pe_d;
    logic                  pt_q, pt_d;
    logic                  sb_q, sb_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  zero_q, zero_d;
    logic                  dv_q, dv_d;
    logic                  par_q, par_d;
    logic                  stp_q, stp_d;
    logic                  brk_q, brk_d;

    logic [5:0] half;
    logic       at_s0, at_s1, at_s2, at_end;
    logic       line, maj, go;
    logic       fin_serr, fin_zero;
    logic [5:0] p_sel;

    assign line   = bus.S_DATA;
    assign half   = {1'b0, p_q[5:1]};
    assign at_s0  = (edge_q == half - 6'd1);
    assign at_s1  = (edge_q == half);
    assign at_s2  = (edge_q == half + 6'd1);
    assign at_end = (edge_q == p_q - 6'd1);
    assign maj    = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);

    // Next-state, counters, sampling, deserialising and output pulses
    always_comb begin
        state_d  = state_q;
        edge_d   = edge_q + 6'd1;
        bit_d    = bit_q;
        p_d      = p_q;
        pe_d     = pe_q;
        pt_d     = pt_q;
        sb_d     = sb_q;
        s0_d     = at_s0 ? line : s0_q;
        s1_d     = at_s1 ? line : s1_q;
        data_d   = data_q;
        pdata_d  = pdata_q;
        perr_d   = perr_q;
        serr_d   = serr_q;
        zero_d   = zero_q;
        dv_d     = 1'b0;
        par_d    = 1'b0;
        stp_d    = 1'b0;
        brk_d    = 1'b0;
        go       = 1'b0;
        fin_serr = serr_q | ~maj;
        fin_zero = zero_q & ((bit_q != 4'd0) | ~maj);
        p_sel    = 6'd8;
        if (bus.prescale == PRESCALE_W'(16)) begin
            p_sel = 6'd16;
        end else if (bus.prescale == PRESCALE_W'(32)) begin
            p_sel = 6'd32;
        end

        unique case (state_q)
            IDLE: begin
                edge_d = 6'd0;
                bit_d  = 4'd0;
                go     = ~line;
            end
            START: begin
                if (at_s2 && maj) begin
                    state_d = IDLE;
                    edge_d  = 6'd0;
                end else if (at_end) begin
                    state_d = DATA;
                    edge_d  = 6'd0;
                    bit_d   = 4'd0;
                end
            end
            DATA: begin
                if (at_s2) begin
                    data_d = {maj, data_q[DATA_WIDTH-1:1]};
                    zero_d = zero_q & ~maj;
                end
                if (at_end) begin
                    edge_d = 6'd0;
                    if (bit_q == 4'(DATA_WIDTH - 1)) begin
                        bit_d   = 4'd0;
                        state_d = pe_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (at_s2) begin
                    perr_d = (maj != (^data_q ^ pt_q));
                    zero_d = zero_q & ~maj;
                end
                if (at_end) begin
                    state_d = STOP;
                    edge_d  = 6'd0;
                    bit_d   = 4'd0;
                end
            end
            STOP: begin
                if (at_s2) begin
                    serr_d = fin_serr;
                    zero_d = fin_zero;
                end
                if (at_s2 && (bit_q == {3'b000, sb_q})) begin
                    state_d = DONE;
                    if (fin_zero) begin
                        brk_d = 1'b1;
                    end else if (perr_q || fin_serr) begin
                        par_d = perr_q;
                        stp_d = fin_serr;
                    end else begin
                        dv_d    = 1'b1;
                        pdata_d = data_q;
                    end
                end else if (at_end) begin
                    edge_d = 6'd0;
                    bit_d  = bit_q + 4'd1;
                end
            end
            DONE: begin
                edge_d = 6'd0;
                if (zero_q) begin
                    state_d = BRK_WAIT;
                end else begin
                    state_d = IDLE;
                    go      = ~line;
                end
            end
            BRK_WAIT: begin
                edge_d = 6'd0;
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = 6'd0;
            end
        endcase

        if (go) begin
            state_d = START;
            edge_d  = 6'd1;
            bit_d   = 4'd0;
            p_d     = p_sel;
            pe_d    = bus.parity_enable;
            pt_d    = bus.parity_type;
            sb_d    = bus.stop_bits;
            perr_d  = 1'b0;
            serr_d  = 1'b0;
            zero_d  = 1'b1;
        end
    end

    // State, counter, configuration and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= 6'd8;
            pe_q    <= 1'b0;
            pt_q    <= 1'b0;
            sb_q    <= 1'b0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            data_q  <= '0;
            pdata_q <= '0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            zero_q  <= 1'b0;
            dv_q    <= 1'b0;
            par_q   <= 1'b0;
            stp_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            pe_q    <= pe_d;
            pt_q    <= pt_d;
            sb_q    <= sb_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            pdata_q <= pdata_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            zero_q  <= zero_d;
            dv_q    <= dv_d;
            par_q   <= par_d;
            stp_q   <= stp_d;
            brk_q   <= brk_d;
        end
    end

    assign bus.P_DATA     = pdata_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = par_q;
    assign bus.stp_err    = stp_q;
    assign bus.break_det  = brk_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: 8-bit and 7-bit receivers share one line and
// are compared every cycle against a frame-level model of the line history.
module tb_uart_rx_engine;
    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_DONE  = 2;
    localparam int M_DONEB = 3;
    localparam int M_BRK   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic       pen = 1'b0;
    logic       ptyp = 1'b0;
    logic       sbits = 1'b0;
    logic [5:0] pre = 6'd8;
    int         cyc = 0;

    uart_rx_engine_if #(.DATA_WIDTH(8)) b8 ();
    uart_rx_engine_if #(.DATA_WIDTH(7)) b7 ();

    assign b8.S_DATA = line;
    assign b8.parity_enable = pen;
    assign b8.parity_type = ptyp;
    assign b8.stop_bits = sbits;
    assign b8.prescale = pre;
    assign b7.S_DATA = line;
    assign b7.parity_enable = pen;
    assign b7.parity_type = ptyp;
    assign b7.stop_bits = sbits;
    assign b7.prescale = pre;

    uart_rx_engine #(.DATA_WIDTH(8)) dut8 (.CLK(clk), .RST(rst_n), .bus(b8));
    uart_rx_engine #(.DATA_WIDTH(7)) dut7 (.CLK(clk), .RST(rst_n), .bus(b7));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit hist [65536];
    int m_mode [2], m_t0 [2], m_p [2];
    bit m_pe [2], m_pt [2], m_sb [2];
    bit e_busy [2], e_dv [2], e_par [2], e_stp [2], e_brk [2];
    int e_pd [2];
    int n_tests = 0, n_fail = 0, n_print = 0;
    int last_dv [2], last_par [2], last_stp [2], last_brk [2];
    int busy_fall [2], dv_cnt [2];
    bit prev_busy [2];

    function automatic int eff_p(input logic [5:0] pr);
        return (pr == 6'd16) ? 16 : ((pr == 6'd32) ? 32 : 8);
    endfunction

    function automatic bit hs(input int t);
        return hist[t & 65535];
    endfunction

    function automatic bit mbit(input int t0, input int p, input int k);
        int c;
        int s;
        c = t0 + p * k + p / 2;
        s = int'(hs(c - 1)) + int'(hs(c)) + int'(hs(c + 1));
        return s >= 2;
    endfunction

    task automatic model_reset(input int i);
        m_mode[i] = M_IDLE;
        e_busy[i] = 0; e_dv[i] = 0; e_par[i] = 0;
        e_stp[i] = 0; e_brk[i] = 0; e_pd[i] = 0;
    endtask

    task automatic model_start(input int i, input int t);
        m_mode[i] = M_FRAME;
        m_t0[i] = t;
        m_p[i] = eff_p(pre);
        m_pe[i] = pen;
        m_pt[i] = ptyp;
        m_sb[i] = sbits;
    endtask

    task automatic model_eval(input int i, input int w);
        int data, s, p, t0;
        bit b, zero, perr, serr, pexp;
        p = m_p[i]; t0 = m_t0[i];
        data = 0; zero = 1; perr = 0; serr = 0;
        for (int k = 1; k <= w; k++) begin
            b = mbit(t0, p, k);
            if (b) begin data |= (1 << (k - 1)); zero = 0; end
        end
        s = w + 1;
        if (m_pe[i]) begin
            b = mbit(t0, p, s);
            if (b) zero = 0;
            pexp = (($countones(data) & 1) != 0) ^ m_pt[i];
            perr = (b != pexp);
            s++;
        end
        for (int j = 0; j <= int'(m_sb[i]); j++) begin
            b = mbit(t0, p, s + j);
            if (!b) serr = 1;
            if (j == 0 && b) zero = 0;
        end
        if (zero) begin
            e_brk[i] = 1;
            m_mode[i] = M_DONEB;
        end else begin
            if (perr || serr) begin
                e_par[i] = perr;
                e_stp[i] = serr;
            end else begin
                e_dv[i] = 1;
                e_pd[i] = data;
            end
            m_mode[i] = M_DONE;
        end
    endtask

    task automatic model_step(input int i, input int t);
        int w, p, rel, n;
        w = (i == 0) ? 8 : 7;
        p = m_p[i];
        rel = t - m_t0[i];
        e_dv[i] = 0; e_par[i] = 0; e_stp[i] = 0; e_brk[i] = 0;
        case (m_mode[i])
            M_IDLE, M_DONE: begin
                if (!hs(t)) model_start(i, t);
                else m_mode[i] = M_IDLE;
            end
            M_DONEB: m_mode[i] = M_BRK;
            M_BRK: if (hs(t)) m_mode[i] = M_IDLE;
            default: begin
                n = w + int'(m_pe[i]) + (m_sb[i] ? 2 : 1);
                if (rel == p / 2 + 1 && mbit(m_t0[i], p, 0))
                    m_mode[i] = M_IDLE;
                else if (rel == p * n + p / 2 + 1)
                    model_eval(i, w);
            end
        endcase
        e_busy[i] = (m_mode[i] != M_IDLE);
    endtask

    // Per-cycle comparison of both receivers against the model
    always @(negedge clk) begin
        logic [4:0] act, exp;
        int apd;
        hist[cyc & 65535] = line;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                act = {b8.busy, b8.data_valid, b8.par_err, b8.stp_err, b8.break_det};
                apd = int'(b8.P_DATA);
            end else begin
                act = {b7.busy, b7.data_valid, b7.par_err, b7.stp_err, b7.break_det};
                apd = int'(b7.P_DATA);
            end
            if (!rst_n) model_reset(i);
            exp = {e_busy[i], e_dv[i], e_par[i], e_stp[i], e_brk[i]};
            n_tests++;
            if (act !== exp || apd != e_pd[i]) begin
                n_fail++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL cycle_check dut%0d cyc %0d: busy/dv/par/stp/brk %b pdata %h, want %b pdata %h",
                             i, cyc, act, apd, exp, e_pd[i]);
                end
            end
            if (act[3]) begin last_dv[i] = cyc; dv_cnt[i]++; end
            if (act[2]) last_par[i] = cyc;
            if (act[1]) last_stp[i] = cyc;
            if (act[0]) last_brk[i] = cyc;
            if (prev_busy[i] && !act[4]) busy_fall[i] = cyc;
            prev_busy[i] = act[4];
            if (rst_n) model_step(i, cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic hold(input bit b, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            line = b;
        end
    endtask

    task automatic scramble_cfg();
        pen = 1'($urandom);
        ptyp = 1'($urandom);
        sbits = 1'($urandom);
        pre = 6'($urandom);
    endtask

    task automatic send_frame(input int p, input int w, input int data,
                              input bit pe, input bit pt, input bit flip,
                              input bit s1, input bit s2, input bit sb,
                              input int last_len, input bit scr,
                              output int t0);
        bit pb;
        @(posedge clk);
        #1;
        line = 0;
        t0 = cyc;
        hold(0, p - 1);
        if (scr) scramble_cfg();
        for (int k = 0; k < w; k++) hold(1'((data >> k) & 1), p);
        if (pe) begin
            pb = (($countones(data & ((1 << w) - 1)) & 1) != 0) ^ pt ^ flip;
            hold(pb, p);
        end
        hold(s1, sb ? p : last_len);
        if (sb) hold(s2, last_len);
    endtask

    initial begin
        int t0, t1, c0, c1, p, w, gap;
        logic [5:0] pr;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            prev_busy[i] = 0;
            dv_cnt[i] = 0;
            last_dv[i] = -1; last_par[i] = -1;
            last_stp[i] = -1; last_brk[i] = -1; busy_fall[i] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(b8.busy), 0);
        check("reset_pdata", int'(b8.P_DATA), 0);
        check("reset_dv", int'(b8.data_valid), 0);
        rst_n = 1;
        hold(1, 5);

        // 8N1, P=8, 0xA5
        pen = 0; ptyp = 0; sbits = 0; pre = 6'd8;
        send_frame(8, 8, 'hA5, 0, 0, 0, 1, 1, 0, 8, 0, t0);
        hold(1, 20);
        check("8n1_dv_cycle", last_dv[0] - t0, 78);
        check("8n1_pdata", int'(b8.P_DATA), 'hA5);
        check("8n1_busy_end", busy_fall[0] - t0, 79);

        // 8E1, P=16, 0x3C good then bad parity
        pen = 1; ptyp = 0; pre = 6'd16;
        send_frame(16, 8, 'h3C, 1, 0, 0, 1, 1, 0, 16, 0, t0);
        hold(1, 20);
        check("8e1_dv_cycle", last_dv[0] - t0, 170);
        check("8e1_pdata", int'(b8.P_DATA), 'h3C);
        c0 = dv_cnt[0];
        send_frame(16, 8, 'h3C, 1, 0, 1, 1, 1, 0, 16, 0, t0);
        hold(1, 20);
        check("8e1_par_cycle", last_par[0] - t0, 170);
        check("8e1_no_dv", dv_cnt[0] - c0, 0);
        check("8e1_pdata_kept", int'(b8.P_DATA), 'h3C);

        // 7O2, P=32, second stop bit 0
        pen = 1; ptyp = 1; sbits = 1; pre = 6'd32;
        c1 = dv_cnt[1];
        send_frame(32, 7, 'h35, 1, 1, 0, 1, 0, 1, 32, 0, t0);
        hold(1, 40);
        check("7o2_stp_cycle", last_stp[1] - t0, 338);
        check("7o2_no_dv", dv_cnt[1] - c1, 0);

        // Start glitch: 3 low cycles
        pen = 0; ptyp = 0; sbits = 0; pre = 6'd8;
        c0 = dv_cnt[0];
        @(posedge clk);
        #1;
        line = 0;
        t0 = cyc;
        hold(0, 2);
        hold(1, 20);
        check("glitch_idle_cycle", busy_fall[0] - t0, 6);
        check("glitch_no_dv", dv_cnt[0] - c0, 0);

        // Break: low for 20 bit times
        @(posedge clk);
        #1;
        line = 0;
        t0 = cyc;
        hold(0, 159);
        hold(1, 20);
        check("break_cycle", last_brk[0] - t0, 78);
        check("break_release", busy_fall[0] - t0, 161);
        check("break_no_dv", dv_cnt[0] - c0, 0);
        send_frame(8, 8, 'h55, 0, 0, 0, 1, 1, 0, 8, 0, t0);
        hold(1, 20);
        check("after_break_pdata", int'(b8.P_DATA), 'h55);

        // Back-to-back 0x01 then 0xFE, second start 4 cycles after pulse
        c0 = dv_cnt[0];
        send_frame(8, 8, 'h01, 0, 0, 0, 1, 1, 0, 8, 0, t0);
        hold(1, 2);
        send_frame(8, 8, 'hFE, 0, 0, 0, 1, 1, 0, 8, 0, t1);
        hold(1, 20);
        check("b2b_gap", t1 - t0, 82);
        check("b2b_dv_count", dv_cnt[0] - c0, 2);
        check("b2b_dv2_cycle", last_dv[0] - t1, 78);
        check("b2b_pdata", int'(b8.P_DATA), 'hFE);

        // Same, with reset in the middle of the second frame
        c0 = dv_cnt[0];
        send_frame(8, 8, 'h01, 0, 0, 0, 1, 1, 0, 8, 0, t0);
        hold(1, 2);
        hold(0, 30);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("rst_busy", int'(b8.busy), 0);
        check("rst_pdata", int'(b8.P_DATA), 0);
        hold(1, 4);
        rst_n = 1;
        hold(1, 100);
        check("rst_dv_count", dv_cnt[0] - c0, 1);

        // Randomised traffic
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 3))
                0: pr = 6'd8;
                1: pr = 6'd16;
                2: pr = 6'd32;
                default: pr = 6'($urandom_range(0, 63));
            endcase
            p = eff_p(pr);
            pre = pr;
            pen = 1'($urandom);
            ptyp = 1'($urandom);
            sbits = 1'($urandom);
            w = $urandom_range(7, 8);
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1;
                line = 0;
                hold(0, $urandom_range(0, p / 2));
                hold(1, $urandom_range(1, 10));
            end else begin
                send_frame(p, w,
                           ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
                           pen, ptyp, ($urandom_range(0, 4) == 0),
                           ($urandom_range(0, 6) != 0), ($urandom_range(0, 6) != 0),
                           sbits,
                           $urandom_range(0, 1) ? p : p / 2 + 2,
                           1, t0);
            end
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            hold(1, gap);
        end
        hold(1, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
